maxpool_2x2: RTL



---
 rtl/maxpool_2x2.sv | 108 ++++++++++
 1 files changed

// File: rtl/maxpool_2x2.sv
// Streaming 2x2 / stride-2 max-pooling of an 8-bit raster stream.
// Even-row horizontal maxima are parked in a half-width line buffer and combined on odd rows.
module maxpool_2x2 #(
   parameter int IMG_W = 218,
   parameter int IMG_H = 218
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] pxl_in,
   input  logic       valid_in,
   output logic [7:0] pxl_out,
   output logic       valid_out,
   output logic       frame_done
);

   localparam int CW   = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int RW   = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int HALF = IMG_W / 2;
   localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

   localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_WIN_LAST = CW'(2 * (IMG_W / 2) - 1);
   localparam logic [RW-1:0] ROW_WIN_LAST = RW'(2 * (IMG_H / 2) - 1);

   function automatic logic [7:0] umax(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [7:0]    h_q, h_d;
   logic [7:0]    pxl_q, pxl_d;
   logic          vld_q, vld_d;
   logic          done_q, done_d;

   logic [7:0]    line_buf [0:HALF-1];
   logic [AW-1:0] lb_addr;
   logic [7:0]    lb_rd;
   logic [7:0]    hmax;
   logic          odd_col, odd_row, lb_we, pool_en;

   always_comb begin
      lb_addr = AW'(col_q >> 1);
      lb_rd   = line_buf[lb_addr];
      hmax    = umax(h_q, pxl_in);
      odd_col = col_q[0];
      odd_row = row_q[0];
      // The trailing unpaired row of an odd-height frame must not touch the buffer.
      lb_we   = valid_in && odd_col && !odd_row && (row_q < ROW_WIN_LAST);
      pool_en = valid_in && odd_col && odd_row;

      col_d  = col_q;
      row_d  = row_q;
      h_d    = h_q;
      pxl_d  = pxl_q;
      vld_d  = 1'b0;
      done_d = 1'b0;

      if (valid_in) begin
         if (!odd_col) begin
            h_d = pxl_in;
         end
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end

      if (pool_en) begin
         pxl_d  = umax(lb_rd, hmax);
         vld_d  = 1'b1;
         done_d = (row_q == ROW_WIN_LAST) && (col_q == COL_WIN_LAST);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q  <= '0;
         row_q  <= '0;
         h_q    <= '0;
         pxl_q  <= '0;
         vld_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         h_q    <= h_d;
         pxl_q  <= pxl_d;
         vld_q  <= vld_d;
         done_q <= done_d;
      end
   end

   // Contents are never reset: every odd-row read follows an even-row write in the same frame.
   always_ff @(posedge clk) begin
      if (lb_we) begin
         line_buf[lb_addr] <= hmax;
      end
   end

   assign pxl_out    = pxl_q;
   assign valid_out  = vld_q;
   assign frame_done = done_q;

endmodule
